// File: rtl/multiplier_middle_bits.sv
// Sequential 56x56 unsigned shift-and-add multiplier slice returning product bits [109:56].
// One en pulse starts a 56-iteration run; res holds the last completed window.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for en; res holds the previous result
//   RUN   | one partial-product add/shift per edge, 56 edges, then IDLE
module multiplier_middle_bits (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [55:0] a,
    input  logic [55:0] bi,
    output logic [53:0] res
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [111:0]   acc;
    logic [111:0]   mcand;
    logic [111:0]   acc_sum;
    logic [55:0]    mplr;
    logic [5:0]     cnt;
    logic           busy;
    logic           start;
    logic           done;

    assign busy    = (state == RUN);
    assign start   = !busy && en;
    assign done    = busy && (cnt == 6'd55);
    assign acc_sum = mplr[0] ? (acc + mcand) : acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The final iteration's add is folded straight into the result window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
            res   <= '0;
        end else if (start) begin
            acc   <= '0;
            mcand <= {56'd0, a};
            mplr  <= bi;
            cnt   <= '0;
        end else if (busy) begin
            acc   <= acc_sum;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 6'd1;
            if (done) begin
                res <= acc_sum[109:56];
            end
        end
    end

endmodule

// File: tb/tb_multiplier_middle_bits.sv
// Scoreboard bench for multiplier_middle_bits: stimulus queues expected res values
// keyed by cycle, a negedge monitor pops and compares them.
module tb_multiplier_middle_bits;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [55:0] a;
    logic [55:0] bi;
    logic [53:0] res;

    typedef struct {
        int          due;
        logic [53:0] exp;
        string       nm;
    } chk_t;

    chk_t        sb[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    logic [53:0] prev_res = '0;

    localparam logic [55:0] MAX56 = 56'hFF_FFFF_FFFF_FFFF;
    localparam logic [55:0] MSB56 = 56'h80_0000_0000_0000;

    multiplier_middle_bits dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a),
        .bi    (bi),
        .res   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input string nm, input logic [53:0] act, input logic [53:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: res=%h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: res is compared after the edge each entry is due.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                compare(sb[i].nm, res, sb[i].exp);
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                n_vec++;
                n_fail++;
                $display("FAIL %s: check missed at cycle %0d, expected %h", sb[i].nm, sb[i].due, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives a start; caller is at a negedge, en is sampled at the next edge (E0).
    task automatic issue(input logic [55:0] av, input logic [55:0] bv,
                         input logic [53:0] exp, input string nm);
        int   e0;
        chk_t c;
        a  = av;
        bi = bv;
        en = 1'b1;
        e0 = cyc + 1;
        c.due = e0 + 55; c.exp = prev_res; c.nm = {nm, "_hold"};
        sb.push_back(c);
        c.due = e0 + 56; c.exp = exp;      c.nm = nm;
        sb.push_back(c);
        prev_res = exp;
    endtask

    // One isolated op; operands are scrambled after E0 to prove they are not resampled.
    task automatic run_op(input logic [55:0] av, input logic [55:0] bv,
                          input logic [53:0] exp, input string nm);
        tick(1);
        issue(av, bv, exp, nm);
        tick(1);
        en = 1'b0;
        a  = ~av;
        bi = ~bv;
        tick(55);
    endtask

    function automatic logic [53:0] model(input logic [55:0] av, input logic [55:0] bv);
        logic [111:0] p;
        p = {56'd0, av} * {56'd0, bv};
        return p[109:56];
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, res=%h expected completion", res);
        n_fail++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [55:0] ra;
        logic [55:0] rb;
        rst_n = 1'b0;
        en    = 1'b0;
        a     = '0;
        bi    = '0;

        #12;
        compare("reset_low", res, 54'd0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            compare("reset_idle", res, 54'd0);
        end

        run_op(MAX56, MAX56, 54'h3F_FFFF_FFFF_FFFE, "max_operands");
        run_op(MSB56, 56'd2, 54'h1, "window_low_edge");
        run_op(MSB56, MSB56, 54'h0, "window_high_edge");
        run_op(56'd1, MAX56, 54'h0, "below_window");
        run_op(MAX56, MAX56, 54'h3F_FFFF_FFFF_FFFE, "max_again");

        // Busy: ignored pulses at E20 and E56, second op accepted at E57.
        tick(1);
        issue(56'd3, 56'h40_0000_0000_0000, 54'h0, "busy_first");
        tick(1);
        en = 1'b0;
        tick(19);
        en = 1'b1; a = MAX56; bi = MAX56;
        tick(1);
        en = 1'b0;
        tick(35);
        en = 1'b1; a = MAX56; bi = MAX56;
        tick(1);
        issue(MSB56, 56'd4, 54'h2, "busy_second");
        tick(1);
        en = 1'b0;
        tick(55);

        // Reset mid-run: async clear of the held result, then a fresh op.
        tick(1);
        a = MAX56; bi = MAX56; en = 1'b1;
        tick(1);
        en = 1'b0;
        tick(30);
        #2;
        rst_n = 1'b0;
        #1;
        compare("reset_mid_run", res, 54'd0);
        sb.delete();
        prev_res = '0;
        tick(3);
        compare("reset_held", res, 54'd0);
        rst_n = 1'b1;
        tick(2);
        compare("reset_released", res, 54'd0);
        run_op(MSB56, 56'd2, 54'h1, "after_reset");

        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 50 == 0) ra = 56'hdb_e90c_fb52_f766;
            if (i % 50 == 1) ra = 56'hd3_3b1c_9b7c_2ffc;
            run_op(ra, rb, model(ra, rb), "random");
        end

        tick(3);
        if (sb.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d checks pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
